// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side control for the UART receiver.
// Detects the start bit on a synchronized serial line, generates the
// mid-bit shift strobes for the 9-bit shift register and checks the stop bit.
// Optional feature: define UART_RX_START_CHECK_EN to re-sample the line in
// the middle of the start bit and reject short glitches.
`timescale 1ns/1ps

module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int TMR_W = $clog2(CLKS_PER_BIT + HALF + 1);
  // First strobe lands half a bit past the first full bit after detection.
  localparam logic [TMR_W-1:0] FIRST_T = TMR_W'(CLKS_PER_BIT + HALF - 1);
  localparam logic [TMR_W-1:0] BIT_T   = TMR_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_START_CHECK_EN
  localparam logic [TMR_W-1:0] HALF_T  = TMR_W'(HALF - 1);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    STOP_CHK  = 2'd2,
    START_CHK = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic             fe_q, fe_n;
  logic             sync1, sync2, sync_prev;
  logic             start_det;
  logic             strobe, load, glitch;

  // Two-flop synchronizer plus edge history; the history is frozen during
  // STOP_CHK so a start edge landing there is still seen on the first IDLE cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      if (state != STOP_CHK) sync_prev <= sync2;
    end
  end

  assign start_det = (state == IDLE) && sync_prev && !sync2;

  // State, bit timer, bit counter and sticky framing error register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      fe_q    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      fe_q    <= fe_n;
    end
  end

  // Next-state logic, strobe schedule and stop-bit evaluation.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    fe_n      = fe_q;
    strobe    = 1'b0;
    load      = 1'b0;
    glitch    = 1'b0;
    case (state)
      IDLE: begin
        timer_n   = '0;
        bit_cnt_n = '0;
        if (start_det) begin
          fe_n = 1'b0;
`ifdef UART_RX_START_CHECK_EN
          state_n = START_CHK;
`else
          state_n = RECV;
`endif
        end
      end
`ifdef UART_RX_START_CHECK_EN
      START_CHK: begin
        // Timer keeps running into RECV so the strobe schedule is unchanged.
        timer_n = timer + TMR_W'(1);
        if (timer == HALF_T) begin
          if (sync2) begin
            glitch  = 1'b1;
            state_n = IDLE;
            timer_n = '0;
          end else begin
            state_n = RECV;
          end
        end
      end
`endif
      RECV: begin
        if (timer == ((bit_cnt == 4'd0) ? FIRST_T : BIT_T)) begin
          strobe    = 1'b1;
          timer_n   = '0;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) state_n = STOP_CHK;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      STOP_CHK: begin
        if (stop_bit) load = 1'b1;
        else          fe_n = 1'b1;
        state_n   = IDLE;
        timer_n   = '0;
        bit_cnt_n = '0;
      end
      default: begin
        state_n   = IDLE;
        timer_n   = '0;
        bit_cnt_n = '0;
      end
    endcase
  end

  assign shift_strobe  = strobe;
  assign load_buffer   = load;
  // Error is visible in the STOP_CHK cycle itself and drops in the detect cycle.
  assign framing_error = (fe_q && !start_det) || ((state == STOP_CHK) && !stop_bit);
  assign rx_busy       = (state != IDLE) && !glitch;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl at CLKS_PER_BIT = 10 with a
// behavioural 9-bit LSB-first shift register feeding stop_bit.
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial_in = 1'b1;
  logic stop_bit;
  logic shift_strobe, load_buffer, framing_error, rx_busy;
  logic [8:0] sr = 9'h1FF;

  int cyc = 0;
  int pass_cnt = 0;
  int total = 0;

  bit         strb_log [0:4095];
  bit         load_log [0:4095];
  bit         fe_log   [0:4095];
  bit         busy_log [0:4095];
  logic [7:0] data_log [0:4095];

  uart_rx_ctrl #(.CLKS_PER_BIT(10)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .serial_in(serial_in),
    .stop_bit(stop_bit),
    .shift_strobe(shift_strobe),
    .load_buffer(load_buffer),
    .framing_error(framing_error),
    .rx_busy(rx_busy)
  );

  assign stop_bit = sr[8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[8:1]};

  always @(negedge clk) begin
    if (cyc < 4096) begin
      strb_log[cyc] = shift_strobe;
      load_log[cyc] = load_buffer;
      fe_log[cyc]   = framing_error;
      busy_log[cyc] = rx_busy;
      data_log[cyc] = sr[7:0];
    end
  end

  function automatic int count_strb(int lo, int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (strb_log[i]) n++;
    return n;
  endfunction

  function automatic int count_load(int lo, int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (load_log[i]) n++;
    return n;
  endfunction

  // Drives one 8N1 frame; d is the cycle in which start detection happens.
  task automatic drive_frame(input logic [7:0] data, input logic stop,
                             input bit align, output int d);
    if (align) begin @(posedge clk); #1; end
    d = cyc + 2;
    serial_in = 1'b0;
    repeat (10) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      serial_in = data[i];
      repeat (10) @(posedge clk); #1;
    end
    serial_in = stop;
    repeat (10) @(posedge clk); #1;
    serial_in = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++; if (shift_strobe !== 1'b0) $display("FAIL rst_strobe: got %b want 0", shift_strobe); else pass_cnt++;
    total++; if (load_buffer !== 1'b0) $display("FAIL rst_load: got %b want 0", load_buffer); else pass_cnt++;
    total++; if (framing_error !== 1'b0) $display("FAIL rst_fe: got %b want 0", framing_error); else pass_cnt++;
    total++; if (rx_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", rx_busy); else pass_cnt++;
    n_rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    total++; if (rx_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", rx_busy); else pass_cnt++;
  endtask

  task automatic test_good_frame();
    int d;
    drive_frame(8'hA5, 1'b1, 1'b1, d);
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      total++;
      if (strb_log[d + 5 + 10*k] !== 1'b1) $display("FAIL good_strobe%0d: got %b want 1", k, strb_log[d + 5 + 10*k]);
      else pass_cnt++;
    end
    total++; if (count_strb(d, d + 100) != 9) $display("FAIL good_strobe_cnt: got %0d want 9", count_strb(d, d + 100)); else pass_cnt++;
    total++; if (busy_log[d + 1] !== 1'b1) $display("FAIL good_busy: got %b want 1", busy_log[d + 1]); else pass_cnt++;
    total++; if (load_log[d + 96] !== 1'b1) $display("FAIL good_load_pos: got %b want 1", load_log[d + 96]); else pass_cnt++;
    total++; if (count_load(d, d + 100) != 1) $display("FAIL good_load_cnt: got %0d want 1", count_load(d, d + 100)); else pass_cnt++;
    total++; if (data_log[d + 96] !== 8'hA5) $display("FAIL good_data: got %h want a5", data_log[d + 96]); else pass_cnt++;
    total++; if (fe_log[d + 96] !== 1'b0) $display("FAIL good_fe: got %b want 0", fe_log[d + 96]); else pass_cnt++;
    total++; if (busy_log[d + 97] !== 1'b0) $display("FAIL good_busy_end: got %b want 0", busy_log[d + 97]); else pass_cnt++;
  endtask

  task automatic test_framing();
    int d1, d2;
    drive_frame(8'h3C, 1'b0, 1'b1, d1);
    drive_frame(8'hFF, 1'b1, 1'b1, d2);
    repeat (4) @(negedge clk);
    total++; if (count_load(d1, d1 + 100) != 0) $display("FAIL fe_noload: got %0d want 0", count_load(d1, d1 + 100)); else pass_cnt++;
    total++; if (fe_log[d1 + 95] !== 1'b0) $display("FAIL fe_before: got %b want 0", fe_log[d1 + 95]); else pass_cnt++;
    total++; if (fe_log[d1 + 96] !== 1'b1) $display("FAIL fe_set: got %b want 1", fe_log[d1 + 96]); else pass_cnt++;
    total++; if (fe_log[d2 - 1] !== 1'b1) $display("FAIL fe_sticky: got %b want 1", fe_log[d2 - 1]); else pass_cnt++;
    total++; if (fe_log[d2] !== 1'b0) $display("FAIL fe_clear: got %b want 0", fe_log[d2]); else pass_cnt++;
    total++; if (load_log[d2 + 96] !== 1'b1) $display("FAIL fe_next_load: got %b want 1", load_log[d2 + 96]); else pass_cnt++;
    total++; if (data_log[d2 + 96] !== 8'hFF) $display("FAIL fe_next_data: got %h want ff", data_log[d2 + 96]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    drive_frame(8'h00, 1'b1, 1'b1, d1);
    drive_frame(8'hFF, 1'b1, 1'b0, d2);
    repeat (4) @(negedge clk);
    total++; if (d2 - d1 != 100) $display("FAIL b2b_spacing: got %0d want 100", d2 - d1); else pass_cnt++;
    total++; if (load_log[d1 + 96] !== 1'b1) $display("FAIL b2b_load1: got %b want 1", load_log[d1 + 96]); else pass_cnt++;
    total++; if (data_log[d1 + 96] !== 8'h00) $display("FAIL b2b_data1: got %h want 00", data_log[d1 + 96]); else pass_cnt++;
    total++; if (load_log[d2 + 96] !== 1'b1) $display("FAIL b2b_load2: got %b want 1", load_log[d2 + 96]); else pass_cnt++;
    total++; if (data_log[d2 + 96] !== 8'hFF) $display("FAIL b2b_data2: got %h want ff", data_log[d2 + 96]); else pass_cnt++;
    total++; if (count_strb(d1, d2 + 100) != 18) $display("FAIL b2b_strobes: got %0d want 18", count_strb(d1, d2 + 100)); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int d, dd, d2;
    @(posedge clk); #1;
    d = cyc + 2;
    fork
      drive_frame(8'hFF, 1'b1, 1'b0, dd);
      begin
        while (cyc < d + 50) begin @(posedge clk); #1; end
        total++; if (rx_busy !== 1'b1) $display("FAIL mid_busy_pre: got %b want 1", rx_busy); else pass_cnt++;
        n_rst = 1'b0;
        #1;
        total++; if (rx_busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", rx_busy); else pass_cnt++;
        total++; if (shift_strobe !== 1'b0) $display("FAIL mid_strobe: got %b want 0", shift_strobe); else pass_cnt++;
        total++; if (load_buffer !== 1'b0) $display("FAIL mid_load: got %b want 0", load_buffer); else pass_cnt++;
        total++; if (framing_error !== 1'b0) $display("FAIL mid_fe: got %b want 0", framing_error); else pass_cnt++;
        repeat (3) @(posedge clk); #1;
        n_rst = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    total++; if (count_strb(d, d + 50) != 4) $display("FAIL mid_strobes_pre: got %0d want 4", count_strb(d, d + 50)); else pass_cnt++;
    total++; if (count_strb(d + 51, d + 105) != 0) $display("FAIL mid_strobes_post: got %0d want 0", count_strb(d + 51, d + 105)); else pass_cnt++;
    total++; if (count_load(d, d + 105) != 0) $display("FAIL mid_noload: got %0d want 0", count_load(d, d + 105)); else pass_cnt++;
    drive_frame(8'h55, 1'b1, 1'b1, d2);
    repeat (4) @(negedge clk);
    total++; if (load_log[d2 + 96] !== 1'b1) $display("FAIL mid_next_load: got %b want 1", load_log[d2 + 96]); else pass_cnt++;
    total++; if (data_log[d2 + 96] !== 8'h55) $display("FAIL mid_next_data: got %h want 55", data_log[d2 + 96]); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int d;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    d = cyc + 2;
    serial_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    serial_in = 1'b1;
    repeat (105) @(negedge clk);
`ifdef UART_RX_START_CHECK_EN
    total++; if (count_strb(d, d + 100) != 0) $display("FAIL glitch_strobes: got %0d want 0", count_strb(d, d + 100)); else pass_cnt++;
    total++; if (busy_log[d + 4] !== 1'b1) $display("FAIL glitch_busy_hi: got %b want 1", busy_log[d + 4]); else pass_cnt++;
    total++; if (busy_log[d + 5] !== 1'b0) $display("FAIL glitch_busy_lo: got %b want 0", busy_log[d + 5]); else pass_cnt++;
    total++; if (count_load(d, d + 100) != 0) $display("FAIL glitch_noload: got %0d want 0", count_load(d, d + 100)); else pass_cnt++;
`else
    total++; if (count_strb(d, d + 100) != 9) $display("FAIL glitch_strobes: got %0d want 9", count_strb(d, d + 100)); else pass_cnt++;
    total++; if (load_log[d + 96] !== 1'b1) $display("FAIL glitch_load: got %b want 1", load_log[d + 96]); else pass_cnt++;
    total++; if (data_log[d + 96] !== 8'hFF) $display("FAIL glitch_data: got %h want ff", data_log[d + 96]); else pass_cnt++;
    total++; if (fe_log[d + 96] !== 1'b0) $display("FAIL glitch_fe: got %b want 0", fe_log[d + 96]); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_glitch();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", pass_cnt, total);
    $fatal(1, "timeout");
  end

endmodule
